// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU sequencer: op codes, legality check,
// FSM state encoding and default datapath geometry.
package valu_pkg;

    localparam int LANES_DEF = 5;
    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] VADD = 3'b000;
    localparam logic [2:0] VSUB = 3'b001;
    localparam logic [2:0] VAND = 3'b010;
    localparam logic [2:0] VOR  = 3'b011;
    localparam logic [2:0] VXOR = 3'b100;
    localparam logic [2:0] VMUL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [2:0] op);
        logic ok;
        case (op)
            VADD, VSUB, VAND, VOR, VXOR, VMUL: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/valu_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: the requester named by ptr wins ties.
// Purely combinational; the pointer register is owned by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[ptr]) begin
                gnt[ptr] = 1'b1;
            end else if (req[~ptr]) begin
                gnt[~ptr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/valu_ctrl.sv
// Arbitrates two requesters onto the shared 5-lane vector ALU, holds the op
// for its latency, captures the lane results and returns them with valid/ready.
module valu_ctrl
    import valu_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [2:0]             req_ctrl0,
    input  logic [2:0]             req_ctrl1,
    output logic [1:0]             req_ready,
    output logic                   valu_vector_op,
    output logic [2:0]             valu_alucontrol,
    output logic                   valu_sel,
    input  logic [LANES*WIDTH-1:0] valu_result,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic                   rsp_err,
    output logic [LANES*WIDTH-1:0] rsp_data,
    input  logic                   rsp_ready
);

    localparam int DW = LANES * WIDTH;

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("valu_ctrl: MUL_LAT must be within 1..15");
    end

    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    state_t          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic [2:0]      op_q, op_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic [1:0]      gnt;
    logic            arb_en;
    logic            win;
    logic [2:0]      win_op;
    logic            last_cnt;

    // Grants are suppressed while reset is held so every output reads 0.
    assign arb_en   = (state_q == IDLE) && reset;
    assign win      = gnt[1];
    assign win_op   = win ? req_ctrl1 : req_ctrl0;
    assign last_cnt = (cnt_q == ((op_q == VMUL) ? MUL_LAST : 4'd0));

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req_ready       = gnt;
    assign valu_vector_op  = (state_q == EXEC);
    assign valu_alucontrol = (state_q == EXEC) ? op_q : 3'b000;
    assign valu_sel        = owner_q;
    assign rsp_valid       = (state_q == RESP);
    assign rsp_id          = owner_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_data        = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        op_d       = op_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d  = win;
                    op_d     = win_op;
                    rr_ptr_d = ~win;
                    cnt_d    = 4'd0;
                    if (is_legal(win_op)) begin
                        state_d = EXEC;
                    end else begin
                        state_d    = RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (last_cnt) begin
                    rsp_data_d = valu_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            op_q       <= VADD;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_valu_ctrl.sv
// Self-checking bench for valu_ctrl: table-driven transactions with a response
// scoreboard, plus hand-written VMUL sampling, reset-abort and contention sequences.
module tb_valu_ctrl;

    localparam int LANES   = 5;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 3;
    localparam int DW      = LANES * WIDTH;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [2:0]    req_ctrl0;
    logic [2:0]    req_ctrl1;
    logic [1:0]    req_ready;
    logic          valu_vector_op;
    logic [2:0]    valu_alucontrol;
    logic          valu_sel;
    logic [DW-1:0] valu_result;
    logic          rsp_valid;
    logic          rsp_id;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    valid;
        logic [2:0]    c0;
        logic [2:0]    c1;
        logic [DW-1:0] res;
        int            stall;
        logic [1:0]    exp_gnt;
        int            exp_lat;
        logic          exp_err;
    } row_t;

    typedef struct {
        logic          id;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    row_t rows[9];
    exp_t sb[$];

    valu_ctrl #(
        .LANES   (LANES),
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ctrl0       (req_ctrl0),
        .req_ctrl1       (req_ctrl1),
        .req_ready       (req_ready),
        .valu_vector_op  (valu_vector_op),
        .valu_alucontrol (valu_alucontrol),
        .valu_sel        (valu_sel),
        .valu_result     (valu_result),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_err         (rsp_err),
        .rsp_data        (rsp_data),
        .rsp_ready       (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] mk(input logic [31:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = b + 32'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_empty: response with no expected entry");
        end else begin
            e = sb.pop_front();
            check("rsp_id", DW'(rsp_id), DW'(e.id));
            check("rsp_err", DW'(rsp_err), DW'(e.err));
            check("rsp_data", rsp_data, e.data);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, DW'(req_ready), DW'(0));
        check({tag, "_vector_op"}, DW'(valu_vector_op), DW'(0));
        check({tag, "_alucontrol"}, DW'(valu_alucontrol), DW'(0));
        check({tag, "_sel"}, DW'(valu_sel), DW'(0));
        check({tag, "_rsp_valid"}, DW'(rsp_valid), DW'(0));
        check({tag, "_rsp_id"}, DW'(rsp_id), DW'(0));
        check({tag, "_rsp_err"}, DW'(rsp_err), DW'(0));
        check({tag, "_rsp_data"}, rsp_data, DW'(0));
    endtask

    // One table row: drive in IDLE, check grant, follow EXEC, compare response, handshake.
    task automatic apply_row(input row_t r);
        int            lat;
        bit            seen;
        logic          w;
        logic [2:0]    op;
        logic [DW-1:0] exp_data;
        exp_t          e;
        req_valid   = r.valid;
        req_ctrl0   = r.c0;
        req_ctrl1   = r.c1;
        valu_result = r.res;
        rsp_ready   = 1'b0;
        #1;
        check("grant", DW'(req_ready), DW'(r.exp_gnt));
        w        = r.exp_gnt[1];
        op       = w ? r.c1 : r.c0;
        exp_data = r.exp_err ? '0 : r.res;
        e.id = w; e.err = r.exp_err; e.data = exp_data;
        sb.push_back(e);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                seen = 1;
            end else begin
                check("exec_vector_op", DW'(valu_vector_op), DW'(!r.exp_err));
                check("exec_alucontrol", DW'(valu_alucontrol), DW'(op));
                check("exec_sel", DW'(valu_sel), DW'(w));
                check("exec_req_ready", DW'(req_ready), DW'(0));
            end
        end
        check("latency", DW'(lat), DW'(r.exp_lat));
        if (seen) begin
            pop_and_check();
            for (int k = 0; k < r.stall; k++) begin
                @(negedge clk);
                check("stall_rsp_valid", DW'(rsp_valid), DW'(1));
                check("stall_rsp_data", rsp_data, exp_data);
                check("stall_rsp_err", DW'(rsp_err), DW'(r.exp_err));
                check("stall_req_ready", DW'(req_ready), DW'(0));
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check("idle_after_hs_valid", DW'(rsp_valid), DW'(0));
            check("idle_after_hs_grant", DW'(req_ready != 2'b00), DW'(1));
            rsp_ready = 1'b0;
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        logic [1:0] gnt_val[4];
        int         gnt_cyc[4];
        int         grants;
        int         resps;
        int         cyc;
        exp_t       e;

        rows[0] = '{2'b01, 3'b000, 3'b000, mk(32'h5),         0,  2'b01, 2,         1'b0};
        rows[1] = '{2'b10, 3'b000, 3'b110, mk(32'h100),       0,  2'b10, 1+MUL_LAT, 1'b0};
        rows[2] = '{2'b11, 3'b001, 3'b010, mk(32'h2000),      0,  2'b01, 2,         1'b0};
        rows[3] = '{2'b11, 3'b011, 3'b100, mk(32'h30000),     0,  2'b10, 2,         1'b0};
        rows[4] = '{2'b01, 3'b101, 3'b000, mk(32'hdead0000),  0,  2'b01, 1,         1'b1};
        rows[5] = '{2'b01, 3'b010, 3'b000, mk(32'h5a5a0000),  10, 2'b01, 2,         1'b0};
        rows[6] = '{2'b10, 3'b000, 3'b111, mk(32'h77),        0,  2'b10, 1,         1'b1};
        rows[7] = '{2'b10, 3'b000, 3'b011, mk(32'h80000000),  0,  2'b10, 2,         1'b0};
        rows[8] = '{2'b11, 3'b110, 3'b000, mk(32'hcafe0000),  0,  2'b01, 1+MUL_LAT, 1'b0};

        reset       = 1'b0;
        req_valid   = 2'b00;
        req_ctrl0   = 3'b000;
        req_ctrl1   = 3'b000;
        valu_result = '0;
        rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) apply_row(rows[i]);

        // VMUL from requester 1: result must be the value present in the last EXEC cycle.
        req_valid   = 2'b10;
        req_ctrl1   = 3'b110;
        valu_result = mk(32'h1000);
        #1;
        check("vmul_grant", DW'(req_ready), DW'(2'b10));
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            check("vmul_vector_op", DW'(valu_vector_op), DW'(1));
            check("vmul_alucontrol", DW'(valu_alucontrol), DW'(3'b110));
            check("vmul_sel", DW'(valu_sel), DW'(1));
            check("vmul_rsp_valid", DW'(rsp_valid), DW'(0));
            valu_result = mk(32'h1000 * 32'(c + 1));
            if (c == MUL_LAT) begin
                e.id = 1'b1; e.err = 1'b0; e.data = valu_result;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        check("vmul_rsp_valid_c4", DW'(rsp_valid), DW'(1));
        if (rsp_valid) pop_and_check();
        else void'(sb.pop_front());
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        check("vmul_back_idle", DW'(rsp_valid), DW'(0));

        // Reset during VMUL at cnt=1 aborts with no response.
        req_valid = 2'b01;
        req_ctrl0 = 3'b110;
        #1;
        check("abort_grant", DW'(req_ready), DW'(2'b01));
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_vector_op", DW'(valu_vector_op), DW'(1));
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        req_valid = 2'b11;
        req_ctrl0 = 3'b000;
        req_ctrl1 = 3'b000;
        reset     = 1'b1;
        #1;
        check("post_reset_grant", DW'(req_ready), DW'(2'b01));
        check("post_reset_rsp_valid", DW'(rsp_valid), DW'(0));
        req_valid = 2'b00;
        @(negedge clk);

        // Both requesters held high with an always-ready consumer.
        req_valid   = 2'b11;
        valu_result = mk(32'h4242);
        rsp_ready   = 1'b1;
        #1;
        grants = 0;
        resps  = 0;
        cyc    = 0;
        while (resps < 4 && cyc < 60) begin
            if (req_ready != 2'b00 && grants < 4) begin
                gnt_val[grants] = req_ready;
                gnt_cyc[grants] = cyc;
                e.id = req_ready[1]; e.err = 1'b0; e.data = valu_result;
                sb.push_back(e);
                grants++;
            end
            if (rsp_valid) begin
                pop_and_check();
                resps++;
            end
            if (resps == 4) begin
                req_valid = 2'b00;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("contention_responses", DW'(resps), DW'(4));
        check("contention_grants", DW'(grants), DW'(4));
        if (grants == 4) begin
            check("contention_g0", DW'(gnt_val[0]), DW'(2'b01));
            check("contention_g1", DW'(gnt_val[1]), DW'(2'b10));
            check("contention_g2", DW'(gnt_val[2]), DW'(2'b01));
            check("contention_g3", DW'(gnt_val[3]), DW'(2'b10));
            for (int k = 1; k < 4; k++)
                check("contention_gap", DW'(gnt_cyc[k] - gnt_cyc[k-1]), DW'(3));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check("final_idle", DW'(rsp_valid), DW'(0));
        check("sb_drained", DW'(sb.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/valu_ctrl.md
Name: valu_ctrl

Overview:
- Sequencer and arbiter in front of the 5-lane vector ALU. Two requesters share the single vector ALU: the decode issue port (id 0) and a secondary requester (id 1).
- Grants the ALU round-robin and drives its vector_op and ALUControl inputs. Steers the external operand mux, holds the op for its latency, captures the 5 lane results and returns them with a valid/ready response handshake.
- VMUL takes a configurable multi-cycle latency because the lane multipliers are slow combinational paths. All other ops take one cycle.

Parameters:
- LANES, 5, number of vector lanes
- WIDTH, 32, lane width in bits
- MUL_LAT, 3, EXEC cycles held for VMUL (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  2  per-requester request valid
- req_ctrl0  in  3  requester 0 ALUControl code
- req_ctrl1  in  3  requester 1 ALUControl code
- req_ready  out  2  one-hot accept pulse; a request is accepted when req_valid[i] and req_ready[i] are both high
- valu_vector_op  out  1  enable to the vector ALU
- valu_alucontrol  out  3  ALUControl to the vector ALU
- valu_sel  out  1  operand-mux select (owner id)
- valu_result  in  LANES*WIDTH  lane results, lane 0 in the LSBs
- rsp_valid  out  1  response valid
- rsp_id  out  1  id of the requester the response belongs to
- rsp_err  out  1  illegal-op flag
- rsp_data  out  LANES*WIDTH  captured lane results
- rsp_ready  in  1  response consumer ready

Behaviour:
- Op codes:
  - 000 VADD, 001 VSUB, 010 VAND, 011 VOR, 100 VXOR: latency 1
  - 110 VMUL: latency MUL_LAT
  - 101 and 111 are illegal
- Reset (async assert, sync release): state IDLE, rr_ptr=0, cnt=0. All outputs are 0, including rsp_data.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrates among requesters with req_valid high. Priority goes to rr_ptr first, then the other requester.
  - The winner gets req_ready[w]=1 for that single cycle. req_ready is combinational from the IDLE state and req_valid.
  - On accept: owner<=w, op<=req_ctrl(w), rr_ptr<=~w, cnt<=0.
  - Legal op: go to EXEC. Illegal op: go to RESP with rsp_err<=1 and rsp_data<=0.
  - No request: stay in IDLE.
- EXEC:
  - valu_vector_op=1, valu_alucontrol=op and valu_sel=owner, held for all EXEC cycles.
  - cnt increments each cycle.
  - When cnt==lat-1: rsp_data<=valu_result, rsp_err<=0, go to RESP.
  - Outside EXEC, valu_vector_op=0, valu_alucontrol=000 and valu_sel=owner.
- RESP:
  - rsp_valid=1, rsp_id=owner. rsp_data and rsp_err are stable until the handshake.
  - rsp_ready=1 ends the response and returns to IDLE. No new grant happens in that same cycle.
  - rsp_ready=0: hold indefinitely. req_ready stays 0 throughout.
- Latency from the accept cycle (cycle 0):
  - ALU ops: rsp_valid in cycle 2.
  - VMUL: rsp_valid in cycle 1+MUL_LAT.
  - Illegal op: rsp_valid in cycle 1.
- Operand rule: the owner keeps its operands and req_valid stable from accept until its own rsp handshake. A second request from the owner is not accepted before then.
- Simultaneous requests: the rr_ptr holder wins. The loser keeps req_valid high and is served next.
- A single requester asserting continuously is granted every time the block returns to IDLE. The rr_ptr alternates but does not block it.
- Reset asserted mid-op: the op is aborted immediately with no response. Outputs go to their reset values and priority returns to requester 0.
- cnt is 4 bits wide. MUL_LAT outside 1..15 is a compile-time error.
- Lane results are captured unmodified; no flag generation.

Decomposition:
- Shared package valu_pkg holds:
  - ALUControl localparams: VADD, VSUB, VAND, VOR, VXOR, VMUL.
  - An is_legal function.
  - The state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - LANES and WIDTH defaults.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], ptr, en.
  - Output: gnt[1:0], one-hot.
  - Purely combinational; the ptr register lives in valu_ctrl.

Test Plan:
- Reset: reset=0 mid-VMUL at cnt=1 -> all outputs 0 immediately. After release, req_valid=2'b11 grants requester 0.
- VADD: req_valid=01, req_ctrl0=000, valu_result lane0=0x5 -> req_ready=01 in cycle 0; valu_vector_op=1, alucontrol=000 in cycle 1; rsp_valid=1, rsp_id=0, rsp_data lane0=0x5 in cycle 2.
- VMUL, MUL_LAT=3: req_ctrl1=110 -> EXEC for cycles 1-3 with alucontrol=110 and valu_sel=1; rsp_valid in cycle 4 with the result sampled in cycle 3.
- Contention: req_valid=11 held continuously, rsp_ready=1 -> grants alternate 0,1,0,1. Each grant happens one cycle after the previous response handshake.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data stable, req_ready=0. rsp_ready=1 returns the block to IDLE the next cycle.
- Illegal op: req_ctrl0=101 -> valu_vector_op stays 0; rsp_valid in cycle 1 with rsp_err=1 and rsp_data=0.
